// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arb_pkg;

  // Arbiter FSM: issue a byte, see the transmitter go busy, see it go idle again.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACCEPT = 2'd1,
    WAIT_DONE   = 2'd2
  } arb_state_e;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester strictly
// above the pointer, wrapping to the lowest requester when none is above.
module round_robin_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [N-1:0] above_mask;
  logic [N-1:0] req_above;

  // Mask of requester slots that come after the pointer in rotation order.
  always_comb begin
    above_mask = '0;
    for (int j = 0; j < N; j++) begin
      above_mask[j] = (IW'(j) > ptr);
    end
  end

  assign req_above = req & above_mask;

  // Lowest set bit above the pointer wins; otherwise the lowest set bit overall.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = (req != '0);
    if (req_above != '0) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (req_above[j]) begin
          grant     = '0;
          grant[j]  = 1'b1;
          grant_idx = IW'(j);
        end
      end
    end else begin
      for (int j = N - 1; j >= 0; j--) begin
        if (req[j]) begin
          grant     = '0;
          grant[j]  = 1'b1;
          grant_idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin at message granularity: an owner keeps the grant until it
// sends a byte flagged last, or sits idle for LOCK_TIMEOUT cycles.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 11,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_write_data,
  output logic                 uart_write_req,
  input  logic                 uart_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked,
  output logic                 busy
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                locked_d;
  logic                write_req_d;
  logic [NUM_REQ-1:0]  req_ready_d;
  logic [7:0]          write_data_d;
  logic [ID_W-1:0]     grant_id_d;
  logic                busy_d;

  logic [7:0]          req_byte [NUM_REQ];
  logic [NUM_REQ-1:0]  owner_mask;
  logic                owner_valid;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  win_oh;
  logic [ID_W-1:0]     win_idx;
  logic                win_any;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = req_data[g*8 +: 8];
  end

  // While a message is in progress only the owner may be arbitrated.
  assign owner_mask  = NUM_REQ'(1) << grant_id;
  assign owner_valid = |(req_valid & owner_mask);
  assign eligible    = locked ? (req_valid & owner_mask) : req_valid;

  round_robin_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any_grant (win_any)
  );

  // Next-state, lock/timeout and registered-output values.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    to_cnt_d     = to_cnt_q;
    locked_d     = locked;
    write_req_d  = 1'b0;
    req_ready_d  = '0;
    write_data_d = uart_write_data;
    grant_id_d   = grant_id;
    case (state_q)
      IDLE: begin
        if (uart_ready && win_any) begin
          state_d      = WAIT_ACCEPT;
          write_req_d  = 1'b1;
          req_ready_d  = win_oh;
          write_data_d = req_byte[win_idx];
          grant_id_d   = win_idx;
          ptr_d        = win_idx;
          locked_d     = ~req_last[win_idx];
          to_cnt_d     = '0;
        end else if ((LOCK_TIMEOUT > 0) && locked && !owner_valid) begin
          // An owner that has gone quiet gives up the grant after the timeout.
          if (to_cnt_q == TO_W'(LOCK_TIMEOUT)) begin
            locked_d = 1'b0;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      // Also absorbs the requester's one-cycle reaction to req_ready.
      WAIT_ACCEPT: begin
        if (!uart_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || locked_d;
  end

  // State and output registers; reset also clears the byte so every output reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= ID_W'(NUM_REQ - 1);
      to_cnt_q        <= '0;
      locked          <= 1'b0;
      uart_write_req  <= 1'b0;
      req_ready       <= '0;
      uart_write_data <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      to_cnt_q        <= to_cnt_d;
      locked          <= locked_d;
      uart_write_req  <= write_req_d;
      req_ready       <= req_ready_d;
      uart_write_data <= write_data_d;
      grant_id        <= grant_id_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_write_data;
  logic           uart_write_req;
  logic           uart_ready;
  logic [1:0]     grant_id;
  logic           locked;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO), .TO_W(11)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .uart_write_data (uart_write_data),
    .uart_write_req  (uart_write_req),
    .uart_ready      (uart_ready),
    .grant_id        (grant_id),
    .locked          (locked),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;

  // Requester byte queues {last, data}, transmitter model, issued-byte log {id, data}.
  logic [8:0] rq [N][$];
  logic [9:0] log_q [$];
  int tx_cnt    = 0;
  int busy_len  = 2;
  bit force_low = 1'b0;

  // Reference model state.
  int           m_ptr   = N - 1;
  int           m_owner = 0;
  int           m_to    = 0;
  int           m_phase = 0;   // 0 free to issue, 1 awaiting tx busy, 2 awaiting tx idle
  bit           m_locked = 1'b0;
  bit           m_wr     = 1'b0;
  bit           m_busy   = 1'b0;
  logic [N-1:0] m_rdy    = '0;
  logic [7:0]   m_data   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    int w;
    int c;
    if (reset) begin
      m_ptr = N - 1; m_owner = 0; m_to = 0; m_phase = 0;
      m_locked = 1'b0; m_wr = 1'b0; m_busy = 1'b0; m_rdy = '0; m_data = '0;
    end else begin
      m_wr  = 1'b0;
      m_rdy = '0;
      if (m_phase == 0) begin
        elig = '0;
        for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (!m_locked || i == m_owner);
        if (uart_ready && elig != '0) begin
          w = -1;
          for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (w < 0 && elig[c]) w = c;
          end
          m_wr = 1'b1; m_rdy[w] = 1'b1; m_data = req_data[w*8 +: 8];
          m_owner = w; m_ptr = w; m_locked = !req_last[w]; m_to = 0; m_phase = 1;
        end else if (m_locked && !req_valid[m_owner]) begin
          if (m_to == TO) begin m_locked = 1'b0; m_to = 0; end
          else m_to++;
        end
      end else if (m_phase == 1) begin
        if (!uart_ready) m_phase = 2;
      end else begin
        if (uart_ready) m_phase = 0;
      end
      m_busy = (m_phase != 0) || m_locked;
    end
  endtask

  task automatic compare_all();
    chk("write_req",  32'(uart_write_req),  32'(m_wr));
    chk("req_ready",  32'(req_ready),       32'(m_rdy));
    chk("write_data", 32'(uart_write_data), 32'(m_data));
    chk("grant_id",   32'(grant_id),        32'(m_owner));
    chk("locked",     32'(locked),          32'(m_locked));
    chk("busy",       32'(busy),            32'(m_busy));
  endtask

  task automatic apply_reqs();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic drive_next();
    if (uart_write_req === 1'b1) begin
      log_q.push_back({grant_id, uart_write_data});
      tx_cnt = busy_len;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
    end
    uart_ready = (tx_cnt == 0) && !force_low;
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
    apply_reqs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive_next();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int i, input bit last, input logic [7:0] d);
    rq[i].push_back({last, d});
  endtask

  function automatic int q_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic wait_log(input string tag, input int n, input int maxc, output int cyc);
    cyc = 0;
    while (log_q.size() < n && cyc < maxc) begin
      tick();
      cyc++;
    end
    chk(tag, 32'(log_q.size()), 32'(n));
  endtask

  task automatic chk_log(input string tag, input int idx, input int id, input logic [7:0] d);
    logic [9:0] e;
    e = (idx < log_q.size()) ? log_q[idx] : 10'h3ff;
    chk(tag, 32'(e), 32'({id[1:0], d}));
  endtask

  int cyc;
  int base;
  int exp_ids [4] = '{1, 3, 1, 3};

  initial begin
    reset = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    uart_ready = 1'b1;

    // Reset values.
    do_reset();
    chk("rst_write_req", 32'(uart_write_req), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_locked",    32'(locked), 0);
    chk("rst_busy",      32'(busy), 0);

    // Single byte from requester 0.
    push(0, 1'b1, 8'h41);
    apply_reqs();
    wait_log("t1_issue", 1, 20, cyc);
    chk_log("t1_byte", 0, 0, 8'h41);
    repeat (6) tick();

    // Requesters 1 and 3 alternate.
    do_reset();
    log_q.delete();
    push(1, 1'b1, 8'h11); push(1, 1'b1, 8'h12);
    push(3, 1'b1, 8'h31); push(3, 1'b1, 8'h32);
    apply_reqs();
    wait_log("t2_issue", 4, 60, cyc);
    for (int k = 0; k < 4; k++) begin
      logic [9:0] e;
      e = (k < log_q.size()) ? log_q[k] : 10'h3ff;
      chk("t2_order", 32'(e[9:8]), 32'(exp_ids[k]));
    end
    repeat (6) tick();

    // Requester 2 message holds the lock against requester 0.
    do_reset();
    log_q.delete();
    push(2, 1'b0, 8'h41); push(2, 1'b0, 8'h42); push(2, 1'b1, 8'h0A);
    apply_reqs();
    tick();
    for (int k = 0; k < 4; k++) push(0, 1'b1, 8'(8'h30 + k));
    apply_reqs();
    wait_log("t3_issue", 7, 100, cyc);
    chk_log("t3_a",  0, 2, 8'h41);
    chk_log("t3_b",  1, 2, 8'h42);
    chk_log("t3_nl", 2, 2, 8'h0A);
    chk_log("t3_r0", 3, 0, 8'h30);
    repeat (6) tick();

    // Lock timeout: requester 1 goes quiet mid-message, requester 3 waits.
    base = log_q.size();
    push(1, 1'b0, 8'h55);
    apply_reqs();
    wait_log("t4_first", base + 1, 20, cyc);
    push(3, 1'b1, 8'h77);
    apply_reqs();
    wait_log("t4_second", base + 2, 60, cyc);
    chk("t4_gap", 32'(cyc), 13);
    chk_log("t4_r3", base + 1, 3, 8'h77);
    repeat (5) tick();

    // Transmitter held busy: no strobes, then exactly one on release.
    force_low = 1'b1;
    uart_ready = 1'b0;
    push(0, 1'b1, 8'h60); push(2, 1'b1, 8'h62);
    apply_reqs();
    base = log_q.size();
    repeat (20) tick();
    chk("t5_stall", 32'(log_q.size() - base), 0);
    force_low = 1'b0;
    uart_ready = (tx_cnt == 0);
    repeat (2) tick();
    chk("t5_release", 32'(log_q.size() - base), 1);
    chk_log("t5_winner", base, 0, 8'h60);
    cyc = 0;
    while (q_total() > 0 && cyc < 100) begin tick(); cyc++; end
    chk("t5_drain", 32'(q_total()), 0);
    repeat (6) tick();

    // Reset while locked in WAIT_DONE.
    do_reset();
    base = log_q.size();
    push(1, 1'b0, 8'h91); push(2, 1'b1, 8'h92); push(3, 1'b1, 8'h93);
    apply_reqs();
    tick();
    chk_log("t6_first", base, 1, 8'h91);
    chk("t6_locked", 32'(locked), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_req",    32'(uart_write_req), 0);
    chk("t6_rst_ready",  32'(req_ready), 0);
    chk("t6_rst_data",   32'(uart_write_data), 0);
    chk("t6_rst_gid",    32'(grant_id), 0);
    chk("t6_rst_locked", 32'(locked), 0);
    chk("t6_rst_busy",   32'(busy), 0);
    wait_log("t6_next", base + 2, 40, cyc);
    chk_log("t6_lowest", base + 1, 2, 8'h92);

    // Random traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      busy_len = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (rq[r].size() < 4) push(r, 1'($urandom_range(0, 2) == 0 ? 0 : 1), 8'($urandom));
      end
      if ($urandom_range(0, 40) == 0) force_low = ~force_low;
      uart_ready = (tx_cnt == 0) && !force_low;
      apply_reqs();
      tick();
    end
    force_low = 1'b0;
    cyc = 0;
    while ((q_total() > 0 || m_busy) && cyc < 3000) begin tick(); cyc++; end
    chk("rand_drain", 32'(q_total()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. CPU console, debug monitor and boot loader.
- Round-robin arbitration at message granularity: the owner keeps the grant until it sends a byte flagged last, or until it goes idle past a timeout.
- Drives the transmitter's uart_write_data / uart_write_req / uart_ready handshake directly, in place of a single bus-slave front end.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, idle cycles after which a locked owner loses the grant; 0 disables the timeout.
- TO_W, 11, timeout counter width; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending; held until its req_ready pulse.
- req_data  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte i ends a message; releases the lock once sent.
- req_ready  out  NUM_REQ  one-cycle accept pulse, at most one bit set.
- uart_write_data  out  8  byte to the transmitter.
- uart_write_req  out  1  one-cycle write strobe to the transmitter.
- uart_ready  in  1  transmitter idle; drops no later than the cycle after uart_write_req.
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner.
- locked  out  1  a message is in progress.
- busy  out  1  state != IDLE or locked.

Behaviour:
- Reset: all outputs 0, state IDLE, locked 0, timeout counter 0, RR pointer NUM_REQ-1 so requester 0 has first priority.
- Reset mid-byte drops the lock and the in-flight byte. The transmitter already holds that byte, so it still completes.
- States: IDLE, WAIT_ACCEPT, WAIT_DONE. All outputs are registered.
- IDLE, eligible set:
  - Unlocked: all req_valid bits.
  - Locked: only req_valid[grant_id].
- IDLE, issue: if uart_ready=1 and the eligible set is non-empty:
  - Winner = first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Next cycle: uart_write_data = winner's byte, uart_write_req = 1, req_ready[winner] = 1, grant_id = winner, pointer = winner.
  - locked becomes ~req_last[winner].
  - Go to WAIT_ACCEPT.
- IDLE, no issue: uart_ready=0 in IDLE → no issue; stay in IDLE.
- WAIT_ACCEPT: strobes return to 0. Wait for uart_ready=0, then go to WAIT_DONE. This state also covers the requester's one-cycle reaction to its registered req_ready pulse.
- WAIT_DONE: wait for uart_ready=1, then go to IDLE.
- Next-issue spacing: the next issue strobe appears no earlier than 3 cycles after the previous one.
- uart_write_data holds its value until the next issue.
- Lock timeout, when LOCK_TIMEOUT > 0:
  - The counter increments each IDLE cycle while locked and req_valid[grant_id]=0.
  - It clears on any issue or unlock.
  - When it reaches LOCK_TIMEOUT, locked clears the next cycle.
  - Arbitration over all requesters resumes the cycle after that.
  - Owner valid and timeout in the same cycle → owner issues; the counter clears.
- No fairness within a lock. Non-owners wait indefinitely while the owner streams.
- Single requester: issues back-to-back, each at the minimum 3-cycle spacing.
- Simultaneous reset and request: reset wins.
- Data rule: req_data is sampled only in the issue cycle; later changes are ignored.

Decomposition:
- Package uart_tx_arb_pkg: state enum (IDLE, WAIT_ACCEPT, WAIT_DONE) and a clog2-based ID width function.
- Sub-module round_robin_arbiter:
  - Parameterised by N.
  - Inputs: request vector, pointer.
  - Outputs: combinational grant one-hot, grant index, any_grant.
  - Reused later for bus arbitration.
- This block owns the pointer register, the lock and timeout logic, and the FSM.

Test Plan:
- Reset, then req_valid=4'b0001, data 0x41, last=1, uart_ready=1. Expect: one uart_write_req with data 0x41; req_ready=4'b0001 in the same cycle; locked=0; grant_id=0.
- req_valid=4'b1010, all last=1, from reset, ready model of 2 cycles busy per byte. Expect: grant order 1,3,1,3; each req_ready pulse aligned with its uart_write_req.
- Req 2 sends "AB\n" with last on '\n' while req 0 is continuously valid. Expect: bytes 0x41, 0x42, 0x0A from req 2 uninterrupted, then req 0; locked high from 'A' until '\n' is issued.
- LOCK_TIMEOUT=8: req 1 sends a byte with last=0, then drops valid; req 3 valid. Expect: locked clears 8 idle cycles later, then req 3 is granted.
- Hold uart_ready=0 for 20 cycles with requests pending. Expect: no strobe. Release ready → exactly one strobe.
- Assert reset in WAIT_DONE while locked. Expect: all outputs 0 next cycle, pointer back to NUM_REQ-1, next grant goes to the lowest valid requester.
